// File: rtl/multicycle_control.sv
// Multicycle processor controller: ten-state main FSM, ALU decoder,
// condition evaluation and conditional gating of PC/register/memory writes.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc,
  output logic [1:0] alucontrol
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
  logic       condex_q, condex_d;
  logic       nowrite_q, nowrite_d;

  logic       nextpc, branch, regw, memw, aluop, irw_raw;
  logic [1:0] flagw;
  logic       nowrite;
  logic       condex;
  logic       pcs;
  logic       in_exec;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic res;
    n   = f[3];
    z   = f[2];
    cf  = f[1];
    v   = f[0];
    res = 1'b0;
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cf;
      4'b0011: res = ~cf;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cf & ~z;
      4'b1001: res = ~(cf & ~z);
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = ~(~z & (n == v));
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    nextpc    = 1'b0;
    branch    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    aluop     = 1'b0;
    irw_raw   = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_raw   = 1'b1;
        nextpc    = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_MEMADR:  alusrcb = 2'b01;
      S_MEMREAD: adrsrc  = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: aluop = 1'b1;
      S_EXECUTEI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      S_ALUWB: regw = 1'b1;
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 2'b00;
    nowrite    = 1'b0;
    flagw      = 2'b00;
    if (aluop) begin
      case (funct[4:1])
        4'b0100: alucontrol = 2'b00;
        4'b0010: alucontrol = 2'b01;
        4'b0000: alucontrol = 2'b10;
        4'b1100: alucontrol = 2'b11;
        4'b1010: begin
          alucontrol = 2'b01;
          nowrite    = 1'b1;
        end
        default: alucontrol = 2'b00;
      endcase
      // Only arithmetic results produce meaningful carry/overflow.
      flagw = {funct[0], funct[0] & ~alucontrol[1]};
    end
  end

  assign immsrc = op;
  assign regsrc = {op == 2'b01, op == 2'b10};

  assign condex  = cond_eval(cond, flags_q);
  assign in_exec = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

  always_comb begin
    condex_d  = condex_q;
    nowrite_d = nowrite_q;
    flags_d   = flags_q;
    if (state_q == S_DECODE) begin
      condex_d  = condex;
      // Clear so a compare cannot suppress the next instruction's writeback.
      nowrite_d = 1'b0;
    end
    if (in_exec) begin
      nowrite_d = nowrite;
      if (flagw[1] && condex_q) flags_d[3:2] = aluflags[3:2];
      if (flagw[0] && condex_q) flags_d[1:0] = aluflags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      condex_q  <= 1'b0;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      condex_q  <= condex_d;
      nowrite_q <= nowrite_d;
    end
  end

  // Write enables are masked by reset so nothing fires while it is held.
  assign pcs      = branch | (regw & (rd == 4'b1111));
  assign pcwrite  = ~reset & (nextpc | (pcs & condex_q));
  assign regwrite = ~reset & regw & condex_q & ~nowrite_q;
  assign memwrite = ~reset & memw & condex_q;
  assign irwrite  = ~reset & irw_raw;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction vector table feeding a per-cycle
// expectation queue, plus reset corner-case sequences.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] aluflags;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, alusrca;
  logic [1:0] resultsrc, alusrcb, immsrc, regsrc, alucontrol;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .aluflags(aluflags), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
    .resultsrc(resultsrc), .alusrcb(alusrcb), .immsrc(immsrc), .regsrc(regsrc),
    .alucontrol(alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] af;
    int         ncyc;
    logic [19:0] st;
    logic [4:0] pcw, regw, memw, irw, adr;
    logic [9:0] res, alu;
    logic [3:0] flags;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       pcw, regw, memw, irw, adr;
    logic [1:0] res, alu;
  } cyc_t;

  vec_t vecs[$];
  cyc_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string n, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input logic [3:0] c, input logic [3:0] a,
                     input int nc, input logic [19:0] st, input logic [4:0] pcw,
                     input logic [4:0] regw, input logic [4:0] memw, input logic [4:0] adr,
                     input logic [9:0] res, input logic [9:0] alu, input logic [3:0] fl);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.rd = r; v.cond = c; v.af = a;
    v.ncyc = nc; v.st = st; v.pcw = pcw; v.regw = regw; v.memw = memw;
    v.irw = 5'b10000; v.adr = adr; v.res = res; v.alu = alu; v.flags = fl;
    vecs.push_back(v);
  endtask

  // Called at a falling edge with the DUT in FETCH; returns at the falling
  // edge where the next FETCH is visible.
  task automatic apply(input vec_t v);
    cyc_t e, g;
    op = v.op; funct = v.funct; rd = v.rd; cond = v.cond; aluflags = v.af;
    for (int c = 0; c < v.ncyc; c++) begin
      e.st   = v.st[19-4*c -: 4];
      e.pcw  = v.pcw[4-c];
      e.regw = v.regw[4-c];
      e.memw = v.memw[4-c];
      e.irw  = v.irw[4-c];
      e.adr  = v.adr[4-c];
      e.res  = v.res[9-2*c -: 2];
      e.alu  = v.alu[9-2*c -: 2];
      sb.push_back(e);
    end
    #1;
    check({v.name, ".immsrc"}, 32'(immsrc), 32'(v.op));
    check({v.name, ".regsrc"}, 32'(regsrc), 32'({v.op == 2'b01, v.op == 2'b10}));
    for (int c = 0; c < v.ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      g = sb.pop_front();
      check($sformatf("%s.c%0d.state", v.name, c), 32'(dut.state_q), 32'(g.st));
      check($sformatf("%s.c%0d.pcwrite", v.name, c), 32'(pcwrite), 32'(g.pcw));
      check($sformatf("%s.c%0d.regwrite", v.name, c), 32'(regwrite), 32'(g.regw));
      check($sformatf("%s.c%0d.memwrite", v.name, c), 32'(memwrite), 32'(g.memw));
      check($sformatf("%s.c%0d.irwrite", v.name, c), 32'(irwrite), 32'(g.irw));
      check($sformatf("%s.c%0d.adrsrc", v.name, c), 32'(adrsrc), 32'(g.adr));
      check($sformatf("%s.c%0d.resultsrc", v.name, c), 32'(resultsrc), 32'(g.res));
      check($sformatf("%s.c%0d.alucontrol", v.name, c), 32'(alucontrol), 32'(g.alu));
    end
    @(negedge clk);
    #1;
    check({v.name, ".flags"}, 32'(dut.flags_q), 32'(v.flags));
    check({v.name, ".next_fetch"}, 32'(dut.state_q), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //   name       op     funct      rd    cond   af     n  states    pcw       regw      memw      adr       resultsrc        alucontrol       flags
    add("add_s",   2'b00, 6'b001001, 4'd2, 4'hE, 4'b0100, 4, 20'h01680, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b0100);
    add("cmp",     2'b00, 6'b010101, 4'd3, 4'hE, 4'b0100, 4, 20'h01680, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000010000, 4'b0100);
    add("beq_t",   2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, 3, 20'h01900, 5'b10100, 5'b00000, 5'b00000, 5'b00000, 10'b1010100000, 10'b0000000000, 4'b0100);
    add("bne_nt",  2'b10, 6'b000000, 4'd0, 4'h1, 4'b0000, 3, 20'h01900, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010100000, 10'b0000000000, 4'b0100);
    add("ldr",     2'b01, 6'b000001, 4'd3, 4'hE, 4'b0000, 5, 20'h01234, 5'b10000, 5'b00001, 5'b00000, 5'b00010, 10'b1010000001, 10'b0000000000, 4'b0100);
    add("ldr_pc",  2'b01, 6'b000001, 4'hF, 4'hE, 4'b0000, 5, 20'h01234, 5'b10001, 5'b00001, 5'b00000, 5'b00010, 10'b1010000001, 10'b0000000000, 4'b0100);
    add("str_ne",  2'b01, 6'b000000, 4'd4, 4'h1, 4'b0000, 4, 20'h01250, 5'b10000, 5'b00000, 5'b00000, 5'b00010, 10'b1010000000, 10'b0000000000, 4'b0100);
    add("str_al",  2'b01, 6'b000000, 4'd4, 4'hE, 4'b0000, 4, 20'h01250, 5'b10000, 5'b00000, 5'b00010, 5'b00010, 10'b1010000000, 10'b0000000000, 4'b0100);
    add("op11",    2'b11, 6'b111111, 4'hF, 4'hE, 4'b1111, 2, 20'h01000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b0100);
    add("add_nzcv",2'b00, 6'b001001, 4'd2, 4'hE, 4'b1011, 4, 20'h01680, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b1011);
    add("addeq_nx",2'b00, 6'b001001, 4'd2, 4'h0, 4'b0100, 4, 20'h01680, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b1011);
    add("orr_s",   2'b00, 6'b011001, 4'd2, 4'hE, 4'b0100, 4, 20'h01680, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000110000, 4'b0111);
    add("subi",    2'b00, 6'b100100, 4'd5, 4'hE, 4'b1000, 4, 20'h01780, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000010000, 4'b0111);
    add("blt_t",   2'b10, 6'b000000, 4'd0, 4'hB, 4'b0000, 3, 20'h01900, 5'b10100, 5'b00000, 5'b00000, 5'b00000, 10'b1010100000, 10'b0000000000, 4'b0111);
    add("addeq_sf",2'b00, 6'b001001, 4'd2, 4'h0, 4'b0000, 4, 20'h01680, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b0000);
    add("beq_nt",  2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, 3, 20'h01900, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010100000, 10'b0000000000, 4'b0000);
    add("add_nv",  2'b00, 6'b001000, 4'hF, 4'hF, 4'b1111, 4, 20'h01680, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b0000);
    add("add_pc",  2'b00, 6'b001000, 4'hF, 4'hE, 4'b1111, 4, 20'h01680, 5'b10010, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b0000);
    add("add_all", 2'b00, 6'b001001, 4'd1, 4'hE, 4'b1111, 4, 20'h01680, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 10'b1010000000, 10'b0000000000, 4'b1111);

    reset = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0; cond = 4'hE; aluflags = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.state", 32'(dut.state_q), 32'd0);
    check("rst.flags", 32'(dut.flags_q), 32'd0);
    check("rst.pcwrite", 32'(pcwrite), 32'd0);
    check("rst.irwrite", 32'(irwrite), 32'd0);
    check("rst.regwrite", 32'(regwrite), 32'd0);
    check("rst.memwrite", 32'(memwrite), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel.irwrite", 32'(irwrite), 32'd1);
    check("rel.pcwrite", 32'(pcwrite), 32'd1);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulse in the middle of a store's MEMWRITE cycle.
    op = 2'b01; funct = 6'b000000; rd = 4'd4; cond = 4'hE; aluflags = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    check("mid.state_memwrite", 32'(dut.state_q), 32'd5);
    check("mid.memwrite_before", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    check("mid.memwrite_drop", 32'(memwrite), 32'd0);
    check("mid.state_reset", 32'(dut.state_q), 32'd0);
    check("mid.flags_reset", 32'(dut.flags_q), 32'd0);
    check("mid.irwrite_reset", 32'(irwrite), 32'd0);
    @(negedge clk);
    #1;
    check("mid.pcwrite_held", 32'(pcwrite), 32'd0);
    reset = 1'b0;
    #1;
    check("mid.fetch_after", 32'(dut.state_q), 32'd0);
    check("mid.irwrite_after", 32'(irwrite), 32'd1);
    @(negedge clk);
    #1;
    check("mid.decode_after", 32'(dut.state_q), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
